// File: rtl/nibble_serial_subtractor.sv
// ============================================================================
// Module   : nibble_serial_subtractor
// Brief    : Multi-precision A - B - BinIn, one 4-bit slice per clock, LSB first.
// Revision : 1.0
// ============================================================================
`default_nettype none

module four_bit_subs (
    input  logic       Enable,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Bin,
    output logic [3:0] Diff,
    output logic       Bout
);
    logic [4:0] w_full;

    // The fifth bit of the widened difference goes high exactly when the slice borrows.
    assign w_full = {1'b0, A} - {1'b0, B} - {4'b0000, Bin};
    assign Diff   = Enable ? w_full[3:0] : 4'h0;
    assign Bout   = Enable & w_full[4];
endmodule

module nibble_serial_subtractor #(
    parameter int NIBBLES = 4
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Start,
    input  logic [4*NIBBLES-1:0] A,
    input  logic [4*NIBBLES-1:0] B,
    input  logic                 BinIn,
    output logic                 Busy,
    output logic                 Done,
    output logic [4*NIBBLES-1:0] Diff,
    output logic                 Bout,
    output logic                 Zero,
    output logic                 Overflow
);
    localparam int W = 4 * NIBBLES;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;
    localparam logic [3:0] c_LAST = 4'(NIBBLES - 1);

    logic [1:0]   r_state;
    logic [3:0]   r_idx;
    logic         r_borrow;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [W-1:0] r_work;
    logic         r_busy;
    logic         r_done;
    logic [W-1:0] r_diff;
    logic         r_bout;
    logic         r_zero;
    logic         r_ovf;

    logic [5:0]   w_sh;
    logic [3:0]   w_a_nib;
    logic [3:0]   w_b_nib;
    logic [3:0]   w_sub_diff;
    logic         w_sub_bout;
    logic [W-1:0] w_work_next;

    assign w_sh    = {r_idx, 2'b00};
    assign w_a_nib = 4'(r_a >> w_sh);
    assign w_b_nib = 4'(r_b >> w_sh);

    four_bit_subs u_sub (
        .Enable (r_busy),
        .A      (w_a_nib),
        .B      (w_b_nib),
        .Bin    (r_borrow),
        .Diff   (w_sub_diff),
        .Bout   (w_sub_bout)
    );

    // Working value with the current slice merged in; on the last slice this is the full result.
    assign w_work_next = (r_work & ~(W'(4'hF) << w_sh)) | (W'(w_sub_diff) << w_sh);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state  <= c_IDLE;
            r_idx    <= 4'd0;
            r_borrow <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_work   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (Start) begin
                        r_a      <= A;
                        r_b      <= B;
                        r_borrow <= BinIn;
                        r_idx    <= 4'd0;
                        r_work   <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= c_RUN;
                    end else begin
                        r_state  <= c_IDLE;
                    end
                end
                c_RUN: begin
                    r_work   <= w_work_next;
                    r_borrow <= w_sub_bout;
                    r_idx    <= r_idx + 4'd1;
                    if (r_idx == c_LAST) begin
                        r_diff  <= w_work_next;
                        r_bout  <= w_sub_bout;
                        r_zero  <= (w_work_next == '0);
                        r_ovf   <= (r_a[W-1] != r_b[W-1]) && (w_work_next[W-1] != r_a[W-1]);
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign Busy     = r_busy;
    assign Done     = r_done;
    assign Diff     = r_diff;
    assign Bout     = r_bout;
    assign Zero     = r_zero;
    assign Overflow = r_ovf;
endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_subtractor.sv
// ============================================================================
// Module   : tb_nibble_serial_subtractor
// Brief    : Scoreboard bench for nibble_serial_subtractor (NIBBLES=4 and NIBBLES=1).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_nibble_serial_subtractor;
    localparam int N = 4;
    localparam int W = 16;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         zero;
        logic         ovf;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         bin;
    logic         busy, done, bout, zero, ovf;
    logic [W-1:0] diff;

    logic         start1;
    logic [3:0]   a1, b1;
    logic         bin1;
    logic         busy1, done1, bout1, zero1, ovf1;
    logic [3:0]   diff1;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_bad = 0;
    exp_t sb[$];

    nibble_serial_subtractor #(.NIBBLES(N)) u_dut (
        .Clk(clk), .Rst(rst), .Start(start), .A(a), .B(b), .BinIn(bin),
        .Busy(busy), .Done(done), .Diff(diff), .Bout(bout), .Zero(zero), .Overflow(ovf)
    );

    nibble_serial_subtractor #(.NIBBLES(1)) u_dut1 (
        .Clk(clk), .Rst(rst), .Start(start1), .A(a1), .B(b1), .BinIn(bin1),
        .Busy(busy1), .Done(done1), .Diff(diff1), .Bout(bout1), .Zero(zero1), .Overflow(ovf1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk = n_chk + 1;
        if (got !== want) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got=0x%0h want=0x%0h (cyc %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
        exp_t        e;
        logic [W:0]  full;
        full   = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
        e.diff = full[W-1:0];
        e.bout = full[W];
        e.zero = (full[W-1:0] == '0);
        e.ovf  = (ma[W-1] != mb[W-1]) && (full[W-1] != ma[W-1]);
        e.cyc  = 0;
        return e;
    endfunction

    // Called right after a negedge: Start is sampled at the next posedge.
    task automatic drive_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
        exp_t e;
        start = 1'b1;
        a     = ta;
        b     = tb;
        bin   = tbin;
        e     = model(ta, tb, tbin);
        e.cyc = cyc + 1 + N;
        sb.push_back(e);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("diff", 64'(diff), 64'(e.diff));
                chk("bout", 64'(bout), 64'(e.bout));
                chk("zero", 64'(zero), 64'(e.zero));
                chk("ovf", 64'(ovf), 64'(e.ovf));
                chk("latency", 64'(cyc), 64'(e.cyc));
                chk("busy_at_done", 64'(busy), 64'd0);
            end
        end
    end

    initial begin
        int t0;
        logic [W-1:0] held;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_diff", 64'(diff), 64'd0);
        chk("rst_flags", 64'({bout, zero, ovf}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic op with busy-window check
        drive_op(16'h1234, 16'h0235, 1'b0);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            chk("busy_run", 64'(busy), 64'd1);
            if (i < N - 1) chk("diff_stable", 64'(diff), 64'd0);
            @(negedge clk);
        end
        chk("busy_done_cycle", 64'(busy), 64'd0);
        wait_drain();

        drive_op(16'h0000, 16'h0001, 1'b0); @(negedge clk); start = 1'b0; wait_drain();
        drive_op(16'h8000, 16'h0001, 1'b0); @(negedge clk); start = 1'b0; wait_drain();
        drive_op(16'hABCD, 16'hABCD, 1'b0); @(negedge clk); start = 1'b0; wait_drain();
        drive_op(16'hABCD, 16'hABCD, 1'b1); @(negedge clk); start = 1'b0; wait_drain();

        // Start held through RUN with junk operands, then back-to-back in the DONE cycle
        drive_op(16'h7000, 16'h9000, 1'b0);
        @(negedge clk);
        t0   = cyc;
        held = diff;
        a = 16'hFFFF; b = 16'h1111; bin = 1'b1;
        while (cyc < t0 + N) begin
            if (cyc < t0 + N - 1) chk("diff_hold", 64'(diff), 64'(held));
            @(negedge clk);
        end
        chk("done_b2b_first", 64'(done), 64'd1);
        drive_op(16'h0100, 16'h0001, 1'b1);
        @(negedge clk);
        start = 1'b0;
        chk("busy_b2b", 64'(busy), 64'd1);
        wait_drain();

        // Reset in the second RUN cycle discards the operation
        start = 1'b1; a = 16'h5555; b = 16'h1111; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_diff", 64'(diff), 64'd0);
        chk("abort_flags", 64'({bout, zero, ovf}), 64'd0);
        repeat (6) @(negedge clk);
        drive_op(16'h0005, 16'h0002, 1'b1); @(negedge clk); start = 1'b0; wait_drain();

        for (int i = 0; i < 6; i++) begin
            drive_op(16'($urandom), 16'($urandom), 1'($urandom));
            @(negedge clk);
            start = 1'b0;
            wait_drain();
        end

        // Single-slice instance
        start1 = 1'b1; a1 = 4'h3; b1 = 4'h5; bin1 = 1'b0;
        @(negedge clk);
        start1 = 1'b0;
        chk("n1_busy", 64'(busy1), 64'd1);
        chk("n1_done_early", 64'(done1), 64'd0);
        @(negedge clk);
        chk("n1_done", 64'(done1), 64'd1);
        chk("n1_diff", 64'(diff1), 64'hE);
        chk("n1_bout", 64'(bout1), 64'd1);
        chk("n1_ovf", 64'(ovf1), 64'd0);
        chk("n1_zero", 64'(zero1), 64'd0);
        @(negedge clk);
        chk("n1_done_pulse", 64'(done1), 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
